// File: rtl/mem_write_buffer.sv
// Posted-store write buffer: FIFO of pending stores drained to memory
// by an IDLE/WRITE FSM, with newest-match load forwarding.
module mem_write_buffer #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int DEPTH      = 4
) (
   input  logic                  i_Clock,
   input  logic                  i_Reset,
   input  logic [ADDR_WIDTH-1:0] i_Addr,
   input  logic                  i_WrEnable,
   input  logic [DATA_WIDTH-1:0] i_WrData,
   output logic [DATA_WIDTH-1:0] o_RdData,
   output logic                  o_Full,
   output logic                  o_Empty,
   output logic                  o_Overflow,
   output logic [ADDR_WIDTH-1:0] o_MemRdAddr,
   input  logic [DATA_WIDTH-1:0] i_MemRdData,
   output logic                  o_MemWrReq,
   output logic [ADDR_WIDTH-1:0] o_MemWrAddr,
   output logic [DATA_WIDTH-1:0] o_MemWrData,
   input  logic                  i_MemWrAck
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   typedef enum logic {IDLE, WRITE} state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
   logic [DATA_WIDTH-1:0] data_q [DEPTH];
   logic [PW-1:0]         head_q, head_d;
   logic [PW-1:0]         tail_q, tail_d;
   logic [PW:0]           count_q, count_d;
   logic                  ovf_q, ovf_d;
   logic                  push, pop;
   logic [PW-1:0]         fwd_idx;

   // A pop on the same edge frees a slot, so a full buffer still accepts
   assign pop  = (state_q == WRITE) & i_MemWrAck;
   assign push = i_WrEnable & ((count_q != FULL_CNT) | pop);

   always_comb begin
      head_d  = pop  ? head_q + PW'(1) : head_q;
      tail_d  = push ? tail_q + PW'(1) : tail_q;
      count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
      ovf_d   = ovf_q | (i_WrEnable & ~push);
   end

   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   always_ff @(posedge i_Clock) begin
      if (push) begin
         addr_q[tail_q] <= i_Addr;
         data_q[tail_q] <= i_WrData;
      end
   end

   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (count_q != '0) state_d = WRITE;
         WRITE: if (pop && count_d == '0) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      o_MemWrReq  = 1'b0;
      o_MemWrAddr = '0;
      o_MemWrData = '0;
      if (state_q == WRITE) begin
         o_MemWrReq  = 1'b1;
         o_MemWrAddr = addr_q[head_q];
         o_MemWrData = data_q[head_q];
      end
   end

   // Walk oldest to newest so the newest matching entry wins
   always_comb begin
      o_RdData = i_MemRdData;
      fwd_idx  = head_q;
      for (int i = 0; i < DEPTH; i++) begin
         fwd_idx = head_q + PW'(i);
         if ((PW+1)'(i) < count_q && addr_q[fwd_idx] == i_Addr)
            o_RdData = data_q[fwd_idx];
      end
   end

   assign o_MemRdAddr = i_Addr;
   assign o_Full      = (count_q == FULL_CNT);
   assign o_Empty     = (count_q == '0);
   assign o_Overflow  = ovf_q;

endmodule
